uart_apb_tx: RTL
================

# uart_apb_tx

APB-slave UART transmitter: the controller-side counterpart of the serial capture model in the UART testbench. Software writes bytes over APB, polls a busy flag, and the block serialises each byte onto `TXD` as 8N1 frames at a programmable bit period, raising `TX_INT` at frame completion. It is the DUT that the bench's `bus_write`/`bus_read` tasks drive and whose `TXD` feeds the capture model.

## Interface
Parameters:
- `DEFAULT_DIV`, 16'd433: reset value of BAUDDIV; bit period = BAUDDIV+1 CLK cycles.
- `FIFO_DEPTH`, 4: TX FIFO entries, power of two (used only with `UART_TX_FIFO_EN`).

Ports (one clock; reset is synchronous and active-low):
- `CLK` in 1: sole clock, all logic on rising edge.
- `RESETn` in 1: synchronous active-low reset.
- `PSEL` in 1, `PENABLE` in 1, `PWRITE` in 1: APB control.
- `PADDR` in 12: byte address; bits [3:2] decoded, others ignored.
- `PWDATA` in 32: write data.
- `PRDATA` out 32: read data, registered; unmapped bits read 0.
- `PREADY` out 1: tied 1 (zero wait states).
- `TXD` out 1: serial output, idle high.
- `TX_INT` out 1: level interrupt = `INT_PEND & CTRL.INT_EN`.

## Operation
- Registers (offsets from shared package): DATA 0x0 (W: push byte PWDATA[7:0]; R: 0); STAT 0x4; CTRL 0x8; BAUDDIV 0xC (R/W, [15:0]).
- STAT: [0] FULL (holding register/FIFO full), [1] ACTIVE (shifter not IDLE), [2] INT_PEND (W1C), [3] OVERRUN (W1C). Writes to bits [1:0] ignored.
- CTRL: [0] TX_EN, [1] INT_EN. Reset 0.
- Access phase = `PSEL & PENABLE`; write takes effect on that edge; PRDATA updated on setup-phase edge so it is valid in access phase.
- DATA write while FULL: byte dropped, OVERRUN set.
- TX FSM: IDLE -> START -> DATA (8 bits, LSB first, 3-bit counter) -> STOP -> IDLE, or STOP -> START directly if a byte is queued and TX_EN=1 (no idle gap).
- IDLE leaves only when queue non-empty and TX_EN=1; byte popped on the load edge.
- TX_EN cleared mid-frame: current frame completes; queued bytes held.
- INT_PEND set on the last cycle of every stop bit; set wins over same-cycle W1C.
- Baud counter 16-bit, reloaded at every load and bit boundary; BAUDDIV write applies at next reload. BAUDDIV=0 gives 1 cycle/bit.

## Timing
- Reset values: TXD=1, PRDATA=0, TX_INT=0, PREADY=1; STAT=0, CTRL=0, BAUDDIV=DEFAULT_DIV, queue empty, FSM IDLE.
- Write at edge N with FSM IDLE, TX_EN=1: load at edge N+1, TXD low from N+1.
- Each bit (start, 8 data, stop) lasts exactly BAUDDIV+1 cycles; frame = 10*(BAUDDIV+1) cycles.
- FULL reflects the DATA write at edge N by a STAT read whose setup phase is at edge N+1 or later.
- Reset mid-frame: TXD=1 and FSM IDLE on the reset edge; queue flushed.

## Configuration
- `UART_TX_FIFO_EN` defined: FIFO_DEPTH-entry FIFO; FULL = count==FIFO_DEPTH; back-to-back writes accepted until full.
- Not defined: single holding register; FULL set from DATA write until load into shifter; FIFO_DEPTH unused.

## Structure
- Shared `uart_const_pkg.v`: UART_DATA_OFFSET, UART_STAT_OFFSET, UART_CTRL_OFFSET, UART_BAUD_OFFSET, STAT/CTRL bit indices, FSM state encodings.
- One sub-module: `uart_tx_fifo` (sync FIFO, push/pop/full/empty/count), instantiated only under `UART_TX_FIFO_EN`.

## Test plan
- Reset, then read STAT/CTRL/BAUDDIV -> 0x0, 0x0, DEFAULT_DIV; TXD=1 throughout.
- BAUDDIV=3, CTRL=1, write 0x55 -> TXD 0,1,0,1,0,1,0,1,0,1 each held 4 cycles, start low on edge after write; INT_PEND=1 at frame end.
- Write "hello" polling FULL (bench controller_send) -> capture model prints "hello", frames back-to-back when FIFO enabled.
- Fill queue (1 or 4 writes, TX_EN=0) then write 0xAA -> OVERRUN=1, 0xAA never on TXD; W1C 0x8 clears it.
- CTRL=3, frame end -> TX_INT=1; W1C STAT[2] on exact stop-end cycle -> INT_PEND stays 1.
- Assert RESETn mid-DATA bit 4 -> TXD=1 next edge, STAT=0, no partial frame resumes.

Source files
------------

// File: rtl/uart_const_pkg.sv
// uart_const_pkg: register offsets, STAT/CTRL bit indices and TX FSM encoding shared by the UART TX block.
package uart_const_pkg;
  localparam logic [11:0] UART_DATA_OFFSET = 12'h000;
  localparam logic [11:0] UART_STAT_OFFSET = 12'h004;
  localparam logic [11:0] UART_CTRL_OFFSET = 12'h008;
  localparam logic [11:0] UART_BAUD_OFFSET = 12'h00C;
  localparam logic [1:0] UART_DATA_WORD = UART_DATA_OFFSET[3:2];
  localparam logic [1:0] UART_STAT_WORD = UART_STAT_OFFSET[3:2];
  localparam logic [1:0] UART_CTRL_WORD = UART_CTRL_OFFSET[3:2];
  localparam logic [1:0] UART_BAUD_WORD = UART_BAUD_OFFSET[3:2];
  localparam int STAT_FULL     = 0;
  localparam int STAT_ACTIVE   = 1;
  localparam int STAT_INT_PEND = 2;
  localparam int STAT_OVERRUN  = 3;
  localparam int CTRL_TX_EN    = 0;
  localparam int CTRL_INT_EN   = 1;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO (power-of-two depth) with push/pop, full/empty flags and occupancy count.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/uart_apb_tx.sv
// uart_apb_tx: APB-slave 8N1 UART transmitter with programmable bit period and frame-done interrupt.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry TX FIFO; otherwise a single holding register is used.
module uart_apb_tx #(
  parameter logic [15:0] DEFAULT_DIV = 16'd433,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [11:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        TXD,
  output logic        TX_INT
);
  import uart_const_pkg::*;
  tx_state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d, baud_q;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d, q_data;
  logic [1:0] ctrl_q;
  logic [31:0] prdata_q, rdata;
  logic int_q, ovr_q, int_set, load, can_load, bit_end;
  logic q_full, q_empty, wr_acc, data_wr, stat_wr, push, drop;
  logic unused_bits;
  assign wr_acc  = PSEL & PENABLE & PWRITE;
  assign data_wr = wr_acc & (PADDR[3:2] == UART_DATA_WORD);
  assign stat_wr = wr_acc & (PADDR[3:2] == UART_STAT_WORD);
  assign push    = data_wr & ~q_full;
  assign drop    = data_wr & q_full;
  assign unused_bits = ^{PADDR[11:4], PADDR[1:0], PWDATA[31:16]};
`ifdef UART_TX_FIFO_EN
  logic [$clog2(FIFO_DEPTH):0] q_count;
  logic unused_count;
  assign unused_count = ^q_count;
  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk_i(CLK), .rst_ni(RESETn), .push_i(push), .data_i(PWDATA[7:0]), .pop_i(load),
    .data_o(q_data), .full_o(q_full), .empty_o(q_empty), .count_o(q_count)
  );
`else
  logic [7:0] hold_q;
  logic full_q;
  logic unused_depth;
  assign unused_depth = ^FIFO_DEPTH;
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      hold_q <= '0;
      full_q <= 1'b0;
    end else begin
      if (push) hold_q <= PWDATA[7:0];
      full_q <= push | (full_q & ~load);
    end
  end
  assign q_data  = hold_q;
  assign q_full  = full_q;
  assign q_empty = ~full_q;
`endif
  assign can_load = ~q_empty & ctrl_q[CTRL_TX_EN];
  assign bit_end  = cnt_q == '0;
  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? cnt_q : cnt_q - 16'd1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    load    = 1'b0;
    int_set = 1'b0;
    case (state_q)
      ST_IDLE:  load = can_load;
      ST_START: if (bit_end) begin
        state_d = ST_DATA;
        cnt_d   = baud_q;
        bit_d   = '0;
      end
      ST_DATA:  if (bit_end) begin
        state_d = (bit_q == 3'd7) ? ST_STOP : ST_DATA;
        cnt_d   = baud_q;
        bit_d   = bit_q + 3'd1;
        sh_d    = sh_q >> 1;
      end
      default:  if (bit_end) begin
        int_set = 1'b1;
        load    = can_load;
        state_d = ST_IDLE;
      end
    endcase
    if (load) begin
      state_d = ST_START;
      cnt_d   = baud_q;
      sh_d    = q_data;
    end
  end
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
    end
  end
  always_comb begin
    rdata = '0;
    case (PADDR[3:2])
      UART_STAT_WORD: begin
        rdata[STAT_FULL]     = q_full;
        rdata[STAT_ACTIVE]   = state_q != ST_IDLE;
        rdata[STAT_INT_PEND] = int_q;
        rdata[STAT_OVERRUN]  = ovr_q;
      end
      UART_CTRL_WORD: rdata[1:0] = ctrl_q;
      UART_BAUD_WORD: rdata[15:0] = baud_q;
      default: rdata = '0;
    endcase
  end
  // Frame-done and drop events outrank a same-cycle write-1-to-clear.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      ctrl_q   <= '0;
      baud_q   <= DEFAULT_DIV;
      int_q    <= 1'b0;
      ovr_q    <= 1'b0;
      prdata_q <= '0;
    end else begin
      if (wr_acc && PADDR[3:2] == UART_CTRL_WORD) ctrl_q <= PWDATA[1:0];
      if (wr_acc && PADDR[3:2] == UART_BAUD_WORD) baud_q <= PWDATA[15:0];
      int_q <= int_set | (int_q & ~(stat_wr & PWDATA[STAT_INT_PEND]));
      ovr_q <= drop | (ovr_q & ~(stat_wr & PWDATA[STAT_OVERRUN]));
      if (PSEL && !PENABLE) prdata_q <= PWRITE ? '0 : rdata;
    end
  end
  assign PRDATA = prdata_q;
  assign PREADY = 1'b1;
  assign TXD    = (state_q == ST_START) ? 1'b0 : (state_q == ST_DATA) ? sh_q[0] : 1'b1;
  assign TX_INT = int_q & ctrl_q[CTRL_INT_EN];
endmodule
